pong_game_sequencer: RTL and testbench

Match-level controller for the Pong datapath. Decides when the ball engine is held at centre court, when it may step, and which way each serve goes. Keeps both players' scores and ends the match at a fixed winning score. Sits between the frame-timing logic (frame_tick), the ball/paddle datapath (miss events in, ball control out) and the score/text overlay.

---
 rtl/pong_game_sequencer.sv | 152 +++++++++++++++
 tb/tb_pong_game_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pong_game_sequencer.sv
// Match-level controller for Pong: serve hold, ball step enable, scoring and match end.
// Outputs are registered from the next-state value, so they change on the edge that samples the cause.
module pong_game_sequencer #(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned FCNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_reset,
  output logic               ball_move_en,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam logic [FCNT_W-1:0]  SERVE_LD = FCNT_W'(SERVE_FRAMES);
  localparam logic [FCNT_W-1:0]  POINT_LD = FCNT_W'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_LD   = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             cur, nxt;
  logic [FCNT_W-1:0]  fcnt, fcnt_nxt;
  logic [SCORE_W-1:0] score_left_nxt, score_right_nxt;
  logic [SCORE_W-1:0] left_inc, right_inc;
  logic               serve_dir_nxt, winner_nxt;
  logic               start_q, start_rise;
  logic               ball_reset_nxt, ball_move_en_nxt, game_over_nxt;

  assign start_rise = start & ~start_q;
  assign left_inc   = score_left + SCORE_W'(1);
  assign right_inc  = score_right + SCORE_W'(1);
  assign state      = cur;

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur          <= S_IDLE;
      fcnt         <= '0;
      score_left   <= '0;
      score_right  <= '0;
      serve_dir    <= 1'b1;
      winner       <= 1'b0;
      start_q      <= 1'b1;
      ball_reset   <= 1'b1;
      ball_move_en <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      cur          <= nxt;
      fcnt         <= fcnt_nxt;
      score_left   <= score_left_nxt;
      score_right  <= score_right_nxt;
      serve_dir    <= serve_dir_nxt;
      winner       <= winner_nxt;
      start_q      <= start;
      ball_reset   <= ball_reset_nxt;
      ball_move_en <= ball_move_en_nxt;
      game_over    <= game_over_nxt;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    nxt             = cur;
    fcnt_nxt        = fcnt;
    score_left_nxt  = score_left;
    score_right_nxt = score_right;
    serve_dir_nxt   = serve_dir;
    winner_nxt      = winner;
    case (cur)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          nxt             = S_SERVE;
          fcnt_nxt        = SERVE_LD;
          score_left_nxt  = '0;
          score_right_nxt = '0;
          serve_dir_nxt   = 1'b1;
          winner_nxt      = 1'b0;
        end
      end
      S_SERVE, S_POINT: begin
        if (frame_tick) begin
          if (fcnt != '0) fcnt_nxt = fcnt - FCNT_W'(1);
          if (fcnt <= FCNT_W'(1)) begin
            nxt = (cur == S_SERVE) ? S_PLAY : S_SERVE;
            if (cur == S_POINT) fcnt_nxt = SERVE_LD;
          end
        end
      end
      S_PLAY: begin
        if (miss_left && miss_right) begin
          nxt      = S_SERVE;
          fcnt_nxt = SERVE_LD;
        end else if (miss_left) begin
          score_right_nxt = right_inc;
          serve_dir_nxt   = 1'b0;
          if (right_inc == WIN_LD) begin
            nxt        = S_OVER;
            winner_nxt = 1'b1;
          end else begin
            nxt      = S_POINT;
            fcnt_nxt = POINT_LD;
          end
        end else if (miss_right) begin
          score_left_nxt = left_inc;
          serve_dir_nxt  = 1'b1;
          if (left_inc == WIN_LD) begin
            nxt        = S_OVER;
            winner_nxt = 1'b0;
          end else begin
            nxt      = S_POINT;
            fcnt_nxt = POINT_LD;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the upcoming state
  always_comb begin
    ball_reset_nxt   = 1'b1;
    ball_move_en_nxt = 1'b0;
    game_over_nxt    = 1'b0;
    case (nxt)
      S_PLAY: begin
        ball_reset_nxt   = 1'b0;
        ball_move_en_nxt = 1'b1;
      end
      S_POINT: ball_reset_nxt = 1'b0;
      S_OVER:  game_over_nxt  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Randomized scoreboard bench for pong_game_sequencer against a match-level reference model.
module tb_pong_game_sequencer;

  localparam int SF = 2;
  localparam int PF = 3;
  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       rst, frame_tick, start, miss_left, miss_right;
  logic       ball_reset, ball_move_en, serve_dir, game_over, winner;
  logic [3:0] score_left, score_right;
  logic [2:0] state;

  pong_game_sequencer #(
    .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WS), .SCORE_W(4), .FCNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .miss_left(miss_left), .miss_right(miss_right),
    .ball_reset(ball_reset), .ball_move_en(ball_move_en), .serve_dir(serve_dir),
    .score_left(score_left), .score_right(score_right),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ball_reset;
    logic       ball_move_en;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic       winner;
    logic [2:0] state;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: match phase (0 idle,1 serve,2 play,3 point,4 over), scores, ticks left
  int phase, pts_l, pts_r, ticks_left;
  bit dir, champ, start_prev;

  function automatic obs_t model_out();
    obs_t o;
    o.ball_reset   = (phase == 0 || phase == 1 || phase == 4);
    o.ball_move_en = (phase == 2);
    o.serve_dir    = dir;
    o.score_left   = 4'(pts_l);
    o.score_right  = 4'(pts_r);
    o.game_over    = (phase == 4);
    o.winner       = champ;
    o.state        = 3'(phase);
    return o;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit t, input bit ml, input bit mr);
    bit rise;
    if (r) begin
      phase = 0; pts_l = 0; pts_r = 0; ticks_left = 0;
      dir = 1; champ = 0; start_prev = 1;
      return;
    end
    rise = s && !start_prev;
    start_prev = s;
    case (phase)
      0, 4: if (rise) begin
        phase = 1; pts_l = 0; pts_r = 0; dir = 1; champ = 0; ticks_left = SF;
      end
      1: if (t) begin
        ticks_left--;
        if (ticks_left == 0) phase = 2;
      end
      3: if (t) begin
        ticks_left--;
        if (ticks_left == 0) begin phase = 1; ticks_left = SF; end
      end
      2: begin
        if (ml && mr) begin
          phase = 1; ticks_left = SF;
        end else if (ml || mr) begin
          if (ml) pts_r++; else pts_l++;
          dir = mr;
          if (pts_l == WS || pts_r == WS) begin
            phase = 4; champ = ml;
          end else begin
            phase = 3; ticks_left = PF;
          end
        end
      end
      default: phase = 0;
    endcase
  endtask

  task automatic drive(input bit r, input bit s, input bit t, input bit ml, input bit mr);
    @(negedge clk);
    rst = r; start = s; frame_tick = t; miss_left = ml; miss_right = mr;
    model_step(r, s, t, ml, mr);
    exp_q.push_back(model_out());
  endtask

  // Monitor: compares the registered outputs just after every edge that has an expectation
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{ball_reset, ball_move_en, serve_dir, score_left, score_right,
              game_over, winner, state};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got st=%0d br=%b me=%b dir=%b L=%0d R=%0d go=%b win=%b; exp st=%0d br=%b me=%b dir=%b L=%0d R=%0d go=%b win=%b",
                   $time, a.state, a.ball_reset, a.ball_move_en, a.serve_dir, a.score_left,
                   a.score_right, a.game_over, a.winner, e.state, e.ball_reset, e.ball_move_en,
                   e.serve_dir, e.score_left, e.score_right, e.game_over, e.winner);
        end
      end
    end
  end

  initial begin
    bit s;
    rst = 1'b1; start = 1'b1; frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    model_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Button held through reset must not start a match
    repeat (3) drive(1, 1, 0, 0, 0);
    repeat (4) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    repeat (3) drive(0, 1, 1, 0, 0);
    s = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      bit r, t, ml, mr;
      if ($urandom_range(0, 7) == 0) s = ~s;
      r  = ($urandom_range(0, 249) == 0);
      t  = ($urandom_range(0, 2) == 0);
      ml = ($urandom_range(0, 5) == 0);
      mr = ($urandom_range(0, 5) == 0);
      drive(r, s, t, ml, mr);
    end
    drive(0, s, 0, 0, 0);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
